// File: rtl/booth_multiplier_8_bits_pkg.sv
// booth_multiplier_8_bits_pkg: FSM state encoding and iteration constants for the Booth multiplier
package booth_multiplier_8_bits_pkg;
  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;
  localparam int ITER = 8;
  localparam int CNT_W = 3;
  localparam logic [CNT_W-1:0] LAST = CNT_W'(ITER - 1);
endpackage

// File: rtl/adder_subtr_8_bits.sv
// adder_subtr_8_bits: 8-bit adder/subtractor, sum = a + b (m=0) or a - b (m=1); ports a, b, m in; sum, co out
module adder_subtr_8_bits (
  input  logic [7:0] a,
  input  logic [7:0] b,
  input  logic       m,
  output logic [7:0] sum,
  output logic       co
);
  assign {co, sum} = {1'b0, a} + {1'b0, b ^ {8{m}}} + 9'(m);
endmodule

// File: rtl/booth_multiplier_8_bits.sv
// booth_multiplier_8_bits: sequential signed 8x8 radix-2 Booth multiplier; clk, rst, start, multiplicand, multiplier in; busy, done, product out
module booth_multiplier_8_bits
  import booth_multiplier_8_bits_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [7:0]  multiplicand,
  input  logic [7:0]  multiplier,
  output logic        busy,
  output logic        done,
  output logic [15:0] product
);
  state_t state, state_nx;
  logic [7:0] a_r, q_r, m_r;
  logic q_m1;
  logic [CNT_W-1:0] count;
  logic accept, sub, op, ovf, s;
  logic [7:0] add_sum, res, b_eff, a_nx, q_nx;
  adder_subtr_8_bits u_add (
    .a   (a_r),
    .b   (m_r),
    .m   (sub),
    .sum (add_sum),
    .co  ()
  );
  assign accept = start && (state == S_IDLE || state == S_DONE);
  assign sub    = q_r[0] & ~q_m1;
  assign op     = q_r[0] ^ q_m1;
  assign b_eff  = m_r ^ {8{sub}};
  assign res    = op ? add_sum : a_r;
  // The 9-bit true result may overflow 8 bits (e.g. 0 - (-128)); the shifted-in sign must be the true sign, not sum[7].
  assign ovf    = op & (a_r[7] == b_eff[7]) & (res[7] != a_r[7]);
  assign s      = res[7] ^ ovf;
  assign a_nx   = {s, res[7:1]};
  assign q_nx   = {res[0], q_r[7:1]};
  assign busy   = (state == S_RUN);
  assign done   = (state == S_DONE);
  always_comb begin
    state_nx = S_IDLE;
    if (accept) state_nx = S_RUN;
    else if (state == S_RUN) state_nx = (count == LAST) ? S_DONE : S_RUN;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= S_IDLE;
      a_r     <= '0;
      q_r     <= '0;
      m_r     <= '0;
      q_m1    <= 1'b0;
      count   <= '0;
      product <= '0;
    end else begin
      state <= state_nx;
      if (accept) begin
        a_r   <= '0;
        q_r   <= multiplier;
        m_r   <= multiplicand;
        q_m1  <= 1'b0;
        count <= '0;
      end else if (state == S_RUN) begin
        a_r   <= a_nx;
        q_r   <= q_nx;
        q_m1  <= q_r[0];
        count <= count + 1'b1;
        if (count == LAST) product <= {a_nx, q_nx};
      end
    end
  end
endmodule
